// File: rtl/cali_apply.sv
// Per-channel gain calibration: looks up each channel's Q2.14 gain in the calibration RAM
// and emits the rounded, saturated sample stream with frame markers and sticky framing errors.
module cali_apply #(
    parameter int NUM_CH    = 320,
    parameter int AW        = 9,
    parameter int DW        = 16,
    parameter int GAIN_FRAC = 14
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    input  logic          in_sof,
    input  logic [DW-1:0] in_data,
    input  logic          bypass,
    input  logic          err_clear,
    output logic [AW-1:0] ram_address,
    output logic          ram_clken,
    input  logic [DW-1:0] ram_readdata,
    output logic          out_valid,
    output logic          out_sof,
    output logic          out_eof,
    output logic [DW-1:0] out_data,
    output logic          out_sat,
    output logic          short_err,
    output logic          long_err,
    output logic [15:0]   frame_count
);

    localparam logic [0:0]    WAIT_SOF = 1'b0;
    localparam logic [0:0]    IN_FRAME = 1'b1;
    localparam logic [AW-1:0] LAST_CH  = AW'(NUM_CH - 1);
    localparam int            PW       = 2 * DW;
    localparam int            SW       = PW + 1;

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] ch_q, ch_d;
    logic [15:0]   frame_q, frame_d;
    logic          short_q, short_d;
    logic          long_q, long_d;
    logic          clken_q;

    logic [AW-1:0] chan;
    logic          accept, is_eof, short_set, long_set;

    logic          vld_p0, vld_p1, vld_p2;
    logic [DW-1:0] data_p0, data_p1, data_p2;
    logic          sof_p0, sof_p1, sof_p2;
    logic          eof_p0, eof_p1, eof_p2;
    logic          byp_p0, byp_p1, byp_p2;
    logic [DW-1:0] gain_p1;
    logic [PW-1:0] prod_p2;

    logic          out_valid_q, out_sof_q, out_eof_q, out_sat_q;
    logic [DW-1:0] out_data_q;
    logic [DW:0]   rs;

    // Returns {saturated, value}: round-half-up of prod / 2^GAIN_FRAC clamped to DW bits.
    function automatic logic [DW:0] round_sat(input logic [PW-1:0] prod);
        logic [SW-1:0] sum;
        logic [SW-1:0] r;
        sum = SW'(prod) + (SW'(1) << (GAIN_FRAC - 1));
        r   = sum >> GAIN_FRAC;
        if (|r[SW-1:DW]) begin
            return {1'b1, {DW{1'b1}}};
        end
        return {1'b0, r[DW-1:0]};
    endfunction

    always_comb begin
        chan      = in_sof ? '0 : ch_q;
        accept    = in_valid & (in_sof | (state_q == IN_FRAME));
        is_eof    = accept & (chan == LAST_CH);
        short_set = in_valid & in_sof & (state_q == IN_FRAME);
        long_set  = in_valid & ~in_sof & (state_q == WAIT_SOF);
        state_d   = state_q;
        ch_d      = ch_q;
        frame_d   = frame_q;
        if (accept) begin
            if (is_eof) begin
                state_d = WAIT_SOF;
                ch_d    = '0;
                frame_d = frame_q + 16'd1;
            end else begin
                state_d = IN_FRAME;
                ch_d    = chan + AW'(1);
            end
        end
        // A new error event outranks a coincident clear.
        short_d = short_set | (short_q & ~err_clear);
        long_d  = long_set | (long_q & ~err_clear);
    end

    assign ram_address = chan;
    assign rs          = round_sat(prod_p2);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= WAIT_SOF;
            ch_q        <= '0;
            frame_q     <= '0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
            clken_q     <= 1'b0;
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            out_sat_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            frame_q     <= frame_d;
            short_q     <= short_d;
            long_q      <= long_d;
            clken_q     <= 1'b1;
            vld_p0      <= accept;
            vld_p1      <= vld_p0;
            vld_p2      <= vld_p1;
            // Stage 3: round, saturate, register outputs
            out_valid_q <= vld_p2;
            out_sof_q   <= vld_p2 & sof_p2;
            out_eof_q   <= vld_p2 & eof_p2;
            out_sat_q   <= vld_p2 & ~byp_p2 & rs[DW];
            out_data_q  <= byp_p2 ? data_p2 : rs[DW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        // Stage 0: sample accepted, RAM address registered in the RAM on this same edge
        data_p0 <= in_data;
        sof_p0  <= in_sof;
        eof_p0  <= is_eof;
        byp_p0  <= bypass;
        // Stage 1: gain from the RAM paired with its sample
        gain_p1 <= ram_readdata;
        data_p1 <= data_p0;
        sof_p1  <= sof_p0;
        eof_p1  <= eof_p0;
        byp_p1  <= byp_p0;
        // Stage 2: product
        prod_p2 <= PW'(data_p1) * PW'(gain_p1);
        data_p2 <= data_p1;
        sof_p2  <= sof_p1;
        eof_p2  <= eof_p1;
        byp_p2  <= byp_p1;
    end

    assign ram_clken   = clken_q;
    assign out_valid   = out_valid_q;
    assign out_sof     = out_sof_q;
    assign out_eof     = out_eof_q;
    assign out_data    = out_data_q;
    assign out_sat     = out_sat_q;
    assign short_err   = short_q;
    assign long_err    = long_q;
    assign frame_count = frame_q;

endmodule

// File: tb/tb_cali_apply.sv
// Bench for cali_apply: behavioural calibration RAM, scoreboard of expected outputs with due cycles.
module tb_cali_apply;

    localparam int NUM_CH = 320;
    localparam int AW     = 9;
    localparam int DW     = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          in_valid = 1'b0, in_sof = 1'b0, bypass = 1'b0, err_clear = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [AW-1:0] ram_address;
    logic          ram_clken;
    logic [DW-1:0] ram_readdata = '0;
    logic          out_valid, out_sof, out_eof, out_sat, short_err, long_err;
    logic [DW-1:0] out_data;
    logic [15:0]   frame_count;

    always #5 clk = ~clk;

    cali_apply #(.NUM_CH(NUM_CH), .AW(AW), .DW(DW), .GAIN_FRAC(14)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_sof(in_sof),
        .in_data(in_data), .bypass(bypass), .err_clear(err_clear),
        .ram_address(ram_address), .ram_clken(ram_clken), .ram_readdata(ram_readdata),
        .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof), .out_data(out_data),
        .out_sat(out_sat), .short_err(short_err), .long_err(long_err),
        .frame_count(frame_count)
    );

    logic [15:0] gain [0:511];
    logic [15:0] fdata [0:NUM_CH-1];

    always @(posedge clk) if (ram_clken) ram_readdata <= gain[ram_address];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          ch;
        logic        sof;
        logic        eof;
        logic        sat;
        logic [15:0] data;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int tests = 0;
    int fails = 0;

    function automatic exp_t model(input int ch, input logic [15:0] d, input logic byp, input int due);
        exp_t x;
        logic [32:0] p;
        logic [32:0] r;
        p = 33'(d) * 33'(gain[ch]);
        r = (p + 33'd8192) >> 14;
        x.due = due;
        x.ch  = ch;
        x.sof = (ch == 0);
        x.eof = (ch == NUM_CH - 1);
        if (byp) begin
            x.data = d;
            x.sat  = 1'b0;
        end else if (r > 33'd65535) begin
            x.data = 16'hFFFF;
            x.sat  = 1'b1;
        end else begin
            x.data = r[15:0];
            x.sat  = 1'b0;
        end
        return x;
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due < cyc) begin
            tests++;
            fails++;
            $display("FAIL missing_out ch%0d: out_valid=0 at cycle %0d, required 1", q[0].ch, q[0].due);
            void'(q.pop_front());
        end
        if (out_valid === 1'b1) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_out: out_valid=1 data=%h at cycle %0d, required out_valid=0",
                         out_data, cyc);
            end else begin
                e = q.pop_front();
                if (e.due !== cyc || out_data !== e.data || out_sof !== e.sof ||
                    out_eof !== e.eof || out_sat !== e.sat) begin
                    fails++;
                    $display("FAIL sample ch%0d: cyc=%0d data=%h sof=%b eof=%b sat=%b, required cyc=%0d data=%h sof=%b eof=%b sat=%b",
                             e.ch, cyc, out_data, out_sof, out_eof, out_sat,
                             e.due, e.data, e.sof, e.eof, e.sat);
                end
            end
        end
    end

    task automatic send(input logic sof, input logic [15:0] d, input int ch, input logic byp, input logic acc);
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = d;
        bypass   = byp;
        if (acc) q.push_back(model(ch, d, byp, cyc + 4));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        bypass   = 1'b0;
    endtask

    task automatic send_range(input int c0, input int c1, input int byp_from);
        for (int c = c0; c <= c1; c++) send(c == 0, fdata[c], c, c >= byp_from, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d outputs still pending, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic check_zero_outputs(input string name);
        tests++;
        if ({out_valid, out_sof, out_eof, out_sat, out_data, short_err, long_err,
             frame_count, ram_address, ram_clken} !== 48'd0) begin
            fails++;
            $display("FAIL %s: valid=%b sof=%b eof=%b sat=%b data=%h serr=%b lerr=%b fc=%0d addr=%0d clken=%b, required all 0",
                     name, out_valid, out_sof, out_eof, out_sat, out_data, short_err, long_err,
                     frame_count, ram_address, ram_clken);
        end
    endtask

    task automatic apply_reset(input int hold);
        reset_n = 1'b0;
        q.delete();
        #1;
        check_zero_outputs("reset_values");
        repeat (hold) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        tests++;
        if (ram_clken !== 1'b0) begin
            fails++;
            $display("FAIL clken_before_edge: ram_clken=%b, required 0", ram_clken);
        end
        @(posedge clk); #1;
        tests++;
        if (ram_clken !== 1'b1) begin
            fails++;
            $display("FAIL clken_after_edge: ram_clken=%b, required 1", ram_clken);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string name, input logic s, input logic l, input int fc);
        tests++;
        if (short_err !== s || long_err !== l || frame_count !== 16'(fc)) begin
            fails++;
            $display("FAIL %s: short_err=%b long_err=%b frame_count=%0d, required %b %b %0d",
                     name, short_err, long_err, frame_count, s, l, fc);
        end
    endtask

    task automatic test_reset();
        #1;
        apply_reset(3);
        check_status("post_reset", 1'b0, 1'b0, 0);
    endtask

    task automatic test_unity();
        for (int i = 0; i < 512; i++) gain[i] = 16'h4000;
        for (int c = 0; c < NUM_CH; c++) fdata[c] = 16'(c * 7);
        send_range(0, NUM_CH - 1, NUM_CH);
        idle(6);
        check_status("unity", 1'b0, 1'b0, 1);
    endtask

    task automatic test_round_sat();
        for (int c = 0; c < NUM_CH; c++) fdata[c] = 16'(c);
        gain[0] = 16'h2000; fdata[0] = 16'd1;
        gain[1] = 16'h2000; fdata[1] = 16'd2;
        gain[2] = 16'h8000; fdata[2] = 16'h9000;
        gain[3] = 16'h4000; fdata[3] = 16'hFFFF;
        gain[4] = 16'h4001; fdata[4] = 16'hFFFF;
        gain[5] = 16'h2000; fdata[5] = 16'd3;
        send_range(0, NUM_CH - 1, NUM_CH);
        idle(6);
        check_status("round_sat", 1'b0, 1'b0, 2);
    endtask

    task automatic test_per_channel();
        for (int i = 0; i < NUM_CH; i++) gain[i] = 16'(16'h4000 + i);
        for (int c = 0; c < NUM_CH; c++) fdata[c] = 16'h1000;
        send_range(0, NUM_CH - 1, NUM_CH);
        idle(6);
        check_status("per_channel", 1'b0, 1'b0, 3);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < NUM_CH; i++) gain[i] = 16'($urandom_range(0, 65535));
        for (int c = 0; c < NUM_CH; c++) fdata[c] = 16'($urandom_range(0, 65535));
        send_range(0, NUM_CH - 1, NUM_CH);
        send_range(0, NUM_CH - 1, 160);
        idle(6);
        check_status("back_to_back", 1'b0, 1'b0, 5);
    endtask

    task automatic test_short_frame();
        for (int i = 0; i < NUM_CH; i++) gain[i] = 16'h4000 + 16'(i * 3);
        for (int c = 0; c < NUM_CH; c++) fdata[c] = 16'(c * 101);
        send_range(0, 100, NUM_CH);
        send_range(0, NUM_CH - 1, NUM_CH);
        idle(6);
        check_status("short_frame", 1'b1, 1'b0, 6);
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        check_status("short_clear", 1'b0, 1'b0, 6);
    endtask

    task automatic test_long_frame();
        apply_reset(2);
        for (int k = 0; k < 3; k++) send(1'b0, 16'h1234, 0, 1'b0, 1'b0);
        idle(6);
        check_status("orphans", 1'b0, 1'b1, 0);
        send_range(0, NUM_CH - 1, NUM_CH);
        send(1'b0, 16'h5555, 0, 1'b0, 1'b0);
        idle(6);
        check_status("extra_sample", 1'b0, 1'b1, 1);
        err_clear = 1'b1;
        send(1'b0, 16'h0001, 0, 1'b0, 1'b0);
        err_clear = 1'b0;
        check_status("set_beats_clear", 1'b0, 1'b1, 1);
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        check_status("long_clear", 1'b0, 1'b0, 1);
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < NUM_CH; c++) fdata[c] = 16'(c * 13 + 5);
        send_range(0, 149, NUM_CH);
        apply_reset(2);
        idle(6);
        check_status("after_mid_reset", 1'b0, 1'b0, 0);
        send(1'b0, 16'h0042, 0, 1'b0, 1'b0);
        idle(4);
        check_status("orphan_after_reset", 1'b0, 1'b1, 0);
        send_range(0, NUM_CH - 1, NUM_CH);
        idle(6);
        check_status("frame_after_reset", 1'b0, 1'b1, 1);
    endtask

    initial begin
        test_reset();
        test_unity();
        test_round_sat();
        test_per_channel();
        test_back_to_back();
        test_short_frame();
        test_long_frame();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        fails++;
        $display("FAIL timeout: bench still running at %0t, required completion", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
